// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: 1 prep cycle, 32 calc cycles, 1 fix cycle, then a done pulse.
// Build option: define DIV_EN to include the restoring divider; without it div/rem ops finish on time with result 0.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [2:0]      dbg_state
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;

    logic              is_div;
    logic              sa_w, sb_w;
    logic [XLEN-1:0]   abs1, abs2;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [2*XLEN-1:0] iter_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   div_res;

    assign is_div = op_q[2];

    // Signed operands: MULH/DIV/REM treat both as signed, MULHSU only rs1.
    always_comb begin
        sa_w = rs1_q[XLEN-1] & ((op_q == 3'b001) | (op_q == 3'b010) |
                                (op_q == 3'b100) | (op_q == 3'b110));
        sb_w = rs2_q[XLEN-1] & ((op_q == 3'b001) | (op_q == 3'b100) | (op_q == 3'b110));
        abs1 = sa_w ? (~rs1_q + 1'b1) : rs1_q;
        abs2 = sb_w ? (~rs2_q + 1'b1) : rs2_q;
    end

    // Multiply: acc = {partial product, remaining multiplier bits}, shift right each step.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
        mul_step = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    end

`ifdef DIV_EN
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] div_step;
    logic [XLEN-1:0]   quo, rem;

    // Divide: acc = {partial remainder, dividend bits / quotient bits}, shift left each step.
    always_comb begin
        div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
        div_step  = div_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                    : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        iter_step = is_div ? div_step : mul_step;
    end

    always_comb begin
        quo = acc_q[XLEN-1:0];
        rem = acc_q[2*XLEN-1:XLEN];
        if (rs2_q == '0) begin
            div_res = op_q[1] ? rs1_q : '1;
        end else if (op_q[1]) begin
            div_res = sa_q ? (~rem + 1'b1) : rem;
        end else begin
            div_res = (sa_q ^ sb_q) ? (~quo + 1'b1) : quo;
        end
    end
`else
    assign iter_step = mul_step;
    assign div_res   = '0;
`endif

    always_comb begin
        prod    = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
        mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (start) begin
                        op_d    = op;
                        rs1_d   = rs1;
                        rs2_d   = rs2;
                        state_d = S_PREP;
                    end
                end
                S_PREP: begin
                    sa_d    = sa_w;
                    sb_d    = sb_w;
                    cnt_d   = '0;
                    acc_d   = {{XLEN{1'b0}}, (is_div ? abs1 : abs2)};
                    opnd_d  = is_div ? abs2 : abs1;
                    state_d = S_CALC;
                end
                S_CALC: begin
                    acc_d = iter_step;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_FIX: begin
                    result_d = is_div ? div_res : mul_res;
                    state_d  = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
        end
    end

    assign busy      = (state_q == S_PREP) | (state_q == S_CALC) | (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scoreboard of reference-model results, latency counted in
// rising edges after the edge that samples start (done expected 34 edges later).
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        busy, done;
    logic [31:0] result;
    logic [2:0]  dbg_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (o)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
`ifdef DIV_EN
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else begin p = sa % sb; r = p[31:0]; end
            end
            3'd7: r = (b == 0) ? a : a % b;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        if (push) exp_q.push_back(model(o, a, b));
    endtask

    task automatic wait_done(output int lat);
        logic [31:0] e;
        lat = 0;
        while (!done && lat < 100) begin
            step();
            lat++;
        end
        if (!done) begin
            check("done_timeout", done, 1);
        end else begin
            check("sb_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result", result, e);
                last_res = e;
            end
        end
    endtask

    task automatic run_basic(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int lat;
        drive_start(o, a, b, 1'b1);
        step();
        start = 1'b0;
        wait_done(lat);
        check("latency", lat, 34);
    endtask

    initial begin
        int          lat;
        bit          saw;
        logic [2:0]  o;
        logic [31:0] a, b;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0; last_res = '0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        step();

        run_basic(3'd0, 32'd7, 32'hFFFF_FFFD);
        check("mul_7x-3", result, 32'hFFFF_FFEB);
        repeat (3) step();
        check("held_result", result, 32'hFFFF_FFEB);
        check("done_one_cycle", done, 0);

        run_basic(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhu_ones", result, 32'hFFFF_FFFE);
        run_basic(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulh_ones", result, 32'h0000_0000);
        run_basic(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhsu_ones", result, 32'hFFFF_FFFF);
        run_basic(3'd1, 32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom();
            b = (i == 3) ? 32'h8000_0000 : $urandom();
            run_basic(o, a, b);
        end

`ifdef DIV_EN
        run_basic(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf", result, 32'h8000_0000);
        run_basic(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        check("rem_ovf", result, 32'h0);
        run_basic(3'd4, 32'hFFFF_FFF9, 32'd2);
        check("div_neg7_2", result, 32'hFFFF_FFFD);
        run_basic(3'd6, 32'hFFFF_FFF9, 32'd2);
        check("rem_neg7_2", result, 32'hFFFF_FFFF);
        run_basic(3'd5, 32'd100, 32'd0);
        check("divu_by0", result, 32'hFFFF_FFFF);
        run_basic(3'd7, 32'd100, 32'd0);
        check("remu_by0", result, 32'h0000_0064);
        run_basic(3'd4, 32'hFFFF_FF00, 32'd0);
        check("div_by0", result, 32'hFFFF_FFFF);
        run_basic(3'd6, 32'hFFFF_FF00, 32'd0);
        check("rem_by0", result, 32'hFFFF_FF00);
        for (int i = 0; i < 8; i++) begin
            o = 3'($urandom_range(4, 7));
            a = $urandom();
            b = (i == 2) ? 32'd0 : ((i == 5) ? 32'($urandom_range(1, 9)) : $urandom());
            run_basic(o, a, b);
        end
`else
        run_basic(3'd4, 32'd100, 32'd5);
        check("div_disabled", result, 32'h0);
        run_basic(3'd7, 32'd100, 32'd7);
        check("remu_disabled", result, 32'h0);
`endif

        // A start pulse while busy must not disturb the op in flight.
        drive_start(3'd0, 32'd1234, 32'd5678, 1'b1);
        step();
        start = 1'b0;
        repeat (4) step();
        drive_start(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        step();
        start = 1'b0;
        check("ign_busy", busy, 1);
        wait_done(lat);
        check("ign_latency", lat + 5, 34);
        check("ign_result", result, 32'd1234 * 32'd5678);

        // Flush sampled on edge 10, restart sampled on edge 11, done on edge 45.
        step();
        drive_start(3'd0, 32'd3, 32'd5, 1'b0);
        step();
        start = 1'b0;
        saw = 1'b0;
        repeat (9) begin
            step();
            if (done) saw = 1'b1;
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_no_done", {saw, done}, 0);
        check("flush_result_kept", result, last_res);
        drive_start(3'd2, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        step();
        start = 1'b0;
        wait_done(lat);
        check("flush_restart_lat", lat + 11, 45);

        // Flush wins over a simultaneous start.
        step();
        drive_start(3'd0, 32'd9, 32'd9, 1'b0);
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        check("flush_wins_busy", busy, 0);
        check("flush_wins_state", dbg_state, 0);

        // Back-to-back: second start is sampled on the edge that ends the done cycle.
        drive_start(3'd0, 32'h0001_0001, 32'h0000_FFFF, 1'b1);
        step();
        start = 1'b0;
        wait_done(lat);
        check("b2b_first_lat", lat, 34);
        drive_start(3'd3, 32'hCAFE_0000, 32'h0000_BEEF, 1'b1);
        step();
        start = 1'b0;
        check("b2b_busy", busy, 1);
        wait_done(lat);
        check("b2b_second_lat", lat, 34);

        // Reset in the middle of an op clears everything and produces no done.
        step();
        drive_start(3'd1, 32'h7654_3210, 32'h1357_9BDF, 1'b0);
        step();
        start = 1'b0;
        repeat (19) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_state", dbg_state, 0);
        saw = 1'b0;
        repeat (40) begin
            step();
            if (done) saw = 1'b1;
        end
        check("mid_rst_no_done", saw, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk  input  1  sole clock, all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  op request from the microcoded controller, sampled only when busy is low.
REQ-005 The block SHALL have port op  input  3  func3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have ports rs1 and rs2  input  XLEN each  operands; rs1 is the multiplicand/dividend and rs2 is the multiplier/divisor.
REQ-007 The block SHALL have port flush  input  1  abort of the in-flight op.
REQ-008 The block SHALL have port busy  output  1  high while an op is in flight.
REQ-009 The block SHALL have port done  output  1  one-cycle completion pulse; it feeds the controller's ex_no_stay to release a stay microinstruction.
REQ-010 The block SHALL have port result  output  XLEN  op result, valid when done is high and held until the next accepted start.

Function
REQ-011 The FSM SHALL have states IDLE, PREP, CALC, FIX and DONE.
REQ-012 In IDLE or DONE, start=1 and flush=0 SHALL capture op, rs1 and rs2 and move the FSM to PREP.
REQ-013 PREP SHALL take absolute values per signedness (MULH: both signed; MULHSU: rs1 signed only; DIV/REM: both signed), record result sign, clear the iteration counter, then go to CALC.
REQ-014 CALC SHALL perform exactly 32 iterations, one per cycle: shift-add for multiply and restoring shift-subtract for divide, then go to FIX.
REQ-015 FIX SHALL apply the two's-complement sign correction, select the low word (MUL), high word (MULH*), quotient or remainder into result, then go to DONE.
REQ-016 DONE SHALL assert done for one cycle and return to IDLE unless a new start is accepted in the same cycle.
REQ-017 Latency SHALL be fixed: start sampled in cycle T gives done in cycle T+34 for every op, including the special cases.
REQ-018 busy SHALL be high in PREP, CALC and FIX, and low in IDLE and DONE.
REQ-019 start while busy is high SHALL be ignored without side effects.
REQ-020 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder equal to rs1 (signed and unsigned).
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-022 The sign of a signed remainder SHALL follow the dividend, and the quotient SHALL truncate toward zero.
REQ-023 flush=1 in any state SHALL force IDLE on the next edge, suppress done, and leave result unchanged; flush SHALL win over a simultaneous start.
REQ-024 The 64-bit internal accumulator SHALL be sized so the iterations never overflow; all arithmetic SHALL be modulo 2^64 internally, with XLEN-bit outputs.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, result=0, and clear the counter and operand registers.
REQ-026 rst SHALL take priority over start and flush, and reset mid-operation SHALL abort without a done pulse.

Configuration
REQ-027 Macro DIV_EN defined SHALL compile in the divider datapath and all ops in REQ-005.
REQ-028 Without DIV_EN, op[2]=1 SHALL still complete with the REQ-017 latency and done pulse, with result=0, so the controller never hangs; multiply behaviour SHALL be unchanged.

Verification
REQ-029 MUL rs1=7, rs2=0xFFFFFFFD, start in cycle T SHALL give done only in T+34 and result=0xFFFFFFEB.
REQ-030 rs1=rs2=0xFFFFFFFF SHALL give result 0xFFFFFFFE for MULHU, 0x00000000 for MULH, and 0xFFFFFFFF for MULHSU.
REQ-031 With DIV_EN: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-032 DIVU 100/0 SHALL give 0xFFFFFFFF and REMU 100/0 SHALL give 0x00000064; without DIV_EN, DIV 100/5 SHALL give 0 with done at T+34.
REQ-033 flush at T+10 SHALL give no done, busy=0 in T+11, and a start in T+11 SHALL complete at T+45; start pulses at T+5 SHALL be ignored.
REQ-034 Back-to-back: a second start in the done cycle T+34 SHALL produce done at T+68 with the second result; rst at T+20 SHALL clear all outputs by T+21.
